// File: rtl/mult_accumulator.sv
// Multiply-accumulate engine: sums len products of 2-bit unsigned operand pairs
// into an ACC_W-bit accumulator. Define MULT_ACC_SAT_EN to saturate instead of wrap.
module mult_accumulator #(
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       a,
    input  logic [1:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             busy,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic [4:0]       r_remaining;
    logic             r_overflow;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic [3:0]       w_product;
    logic [ACC_W:0]   w_product_ext;
    logic [ACC_W:0]   w_sum;
    logic [ACC_W-1:0] w_acc_next;
    logic             w_accept;

    assign w_product     = {2'b00, a} * {2'b00, b};
    assign w_product_ext = {{(ACC_W-3){1'b0}}, w_product};
    assign w_sum         = {1'b0, r_acc} + w_product_ext;
    assign w_accept      = in_valid & r_in_ready;

`ifdef MULT_ACC_SAT_EN
    // Once the run has overflowed, the accumulator stays pinned at full scale.
    assign w_acc_next = (w_sum[ACC_W] || r_overflow) ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
    assign w_acc_next = w_sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_remaining <= '0;
            r_overflow  <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc       <= '0;
                        r_overflow  <= 1'b0;
                        r_remaining <= (len == 4'd0) ? 5'd16 : {1'b0, len};
                        r_state     <= ACC;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                ACC: begin
                    if (w_accept) begin
                        r_acc       <= w_acc_next;
                        r_overflow  <= r_overflow | w_sum[ACC_W];
                        r_remaining <= r_remaining - 5'd1;
                        if (r_remaining == 5'd1) begin
                            r_state     <= DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign acc_out   = r_acc;
    assign overflow  = r_overflow;

endmodule
